// File: rtl/ps2_pkg.sv
// Shared types and scancode constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_e;

    localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
    localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
    localparam logic [7:0] KEY_SPACE      = 8'h29;
    localparam logic [7:0] KEY_UP         = 8'h75;

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a stability filter: the output follows the
// synchronized line only after FILTER_LEN consecutive samples disagree with it.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic filt_o
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          s1_q, s2_q, filt_q;
    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
            // Any sample matching the current output restarts the run.
            if (s2_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= s2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign filt_o = filt_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host frame receiver with scancode decoder (make/break, E0
// extension) and a held-level jump signal for space / up-arrow.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_error,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_released,
    output logic       key_valid,
    output logic       jump_held
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic fclk, fdata, fclk_prev_q, fall;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
        .clk(clk), .reset(reset), .raw_i(ps2_clk), .filt_o(fclk)
    );
    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
        .clk(clk), .reset(reset), .raw_i(ps2_data), .filt_o(fdata)
    );

    assign fall = fclk_prev_q & ~fclk;

    ps2_state_e    state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          rx_valid_q, rx_valid_d;
    logic          rx_error_q, rx_error_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fclk_prev_q <= 1'b1;
            state_q     <= IDLE;
            bitcnt_q    <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            fclk_prev_q <= fclk;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_error_q  <= rx_error_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = '0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_error_d = 1'b0;

        if (fall) begin
            case (state_q)
                IDLE: begin
                    if (!fdata) begin
                        state_d  = DATA;
                        bitcnt_d = '0;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                end
                DATA: begin
                    shift_d  = {fdata, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = fdata;
                    state_d = STOP;
                end
                STOP: begin
                    if (fdata && ((^shift_q) ^ par_q)) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_error_d = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE) begin
            // An edge in the same cycle takes the branch above, so it wins.
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                rx_error_d = 1'b1;
                state_d    = IDLE;
                shift_d    = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    logic       ext_q, brk_q;
    logic [7:0] key_code_q;
    logic       key_ext_q, key_rel_q, key_valid_q, jump_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            key_code_q  <= '0;
            key_ext_q   <= 1'b0;
            key_rel_q   <= 1'b0;
            key_valid_q <= 1'b0;
            jump_q      <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (rx_error_q) begin
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end else if (rx_valid_q) begin
                if (rx_data_q == PS2_PREFIX_EXT) begin
                    ext_q <= 1'b1;
                end else if (rx_data_q == PS2_PREFIX_BRK) begin
                    brk_q <= 1'b1;
                end else begin
                    key_code_q  <= rx_data_q;
                    key_ext_q   <= ext_q;
                    key_rel_q   <= brk_q;
                    key_valid_q <= 1'b1;
                    ext_q       <= 1'b0;
                    brk_q       <= 1'b0;
                    if ((!ext_q && rx_data_q == KEY_SPACE) || (ext_q && rx_data_q == KEY_UP))
                        jump_q <= ~brk_q;
                end
            end
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_error     = rx_error_q;
    assign key_code     = key_code_q;
    assign key_ext      = key_ext_q;
    assign key_released = key_rel_q;
    assign key_valid    = key_valid_q;
    assign jump_held    = jump_q;

endmodule

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives device-to-host PS/2 keyboard frames on the board's PS/2 lines and decodes the scancode stream into make/break key events plus a held-level jump signal for the game logic. Sits beside the VGA controller in the top level and drives the dino jump request instead of a push-button. Receive-only: the block never drives `ps2_clk` or `ps2_data`.

## Interface
- `FILTER_LEN`, 8: consecutive identical synchronized samples required before a filtered line changes value.
- `TIMEOUT_CYCLES`, 200000: clk cycles (2 ms at 100 MHz) without a filtered falling edge that abort a partial frame.
- `clk`  in  1  100 MHz system clock.
- `reset`  in  1  reset; one clock, reset is asynchronous and active-high.
- `ps2_clk`  in  1  raw PS/2 clock from the keyboard, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `rx_data`  out  8  last correctly received byte.
- `rx_valid`  out  1  one-cycle pulse: `rx_data` updated.
- `rx_error`  out  1  one-cycle pulse: frame discarded (bad start, parity, stop, or timeout).
- `key_code`  out  8  scancode of the last key event, prefixes stripped.
- `key_ext`  out  1  last event was E0-prefixed.
- `key_released`  out  1  last event was a break (F0-prefixed).
- `key_valid`  out  1  one-cycle pulse: `key_*` updated.
- `jump_held`  out  1  level: space (29) or up-arrow (E0 75) currently held.

## Operation
- Each line passes through a 2-flop synchronizer, then a glitch filter: the filtered output (reset 1) takes the synchronized value only after `FILTER_LEN` consecutive equal samples.
- A falling edge is a cycle where filtered `ps2_clk` is 0 and was 1 the previous cycle. Data is sampled from filtered `ps2_data` in that cycle.
- Frame: start 0, 8 data bits LSB first, odd parity, stop 1 (11 falling edges).
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on edge, sampled 0 -> DATA with bit count 0; sampled 1 -> `rx_error`, stay IDLE.
  - DATA: shift the bit in on each edge; after the 8th -> PARITY.
  - PARITY: store the bit -> STOP.
  - STOP: on edge, stop=1 and XOR of the 8 data bits plus parity = 1 -> load `rx_data`, pulse `rx_valid`; otherwise pulse `rx_error`. Either way -> IDLE.
- Timeout: a cycle counter clears on every edge and counts only outside IDLE. Reaching `TIMEOUT_CYCLES` -> `rx_error`, IDLE, shift register cleared.
- Decoder, acting on `rx_valid`:
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - Any other byte: `key_code`=byte, `key_ext`=ext, `key_released`=brk, pulse `key_valid`, then clear both flags.
  - `rx_error` clears both flags.
- `jump_held` sets on a make of (ext=0, 29) or (ext=1, 75) and clears on the matching break. Other keys do not affect it; repeated makes leave it at 1.
- Reset values: all outputs 0, FSM IDLE, flags 0, filtered lines 1, counters 0. Reset mid-frame discards the partial frame with no pulse.

## Timing
- Raw-pin change to filtered change: 2 + `FILTER_LEN` cycles.
- `rx_valid` or `rx_error` is registered and high the cycle after the detecting edge cycle (or the timeout cycle).
- `key_valid` and `jump_held` update the cycle after `rx_valid`, so one cycle after `rx_valid`.
- Pulses are exactly one cycle wide. `rx_valid` and `rx_error` are never high together.
- Timeout and edge in the same cycle: the edge wins and the counter clears.

## Structure
- Shared package `ps2_pkg` holds:
  - FSM state enum.
  - Constants `PS2_PREFIX_EXT`=8'hE0, `PS2_PREFIX_BRK`=8'hF0, `KEY_SPACE`=8'h29, `KEY_UP`=8'h75.
- Sub-module `ps2_line_filter` (synchronizer + `FILTER_LEN` stability counter), instantiated once per line.
- FSM, timeout counter, and decoder live in the top module.

## Test plan
- Frame 29 at 12.5 kHz, parity 0 -> one `rx_valid` with `rx_data`=29; `key_valid` with `key_code`=29, `key_released`=0; `jump_held`=1.
- Frames F0, 29 -> one `key_valid` with `key_released`=1, `key_code`=29; `jump_held`=0; no `key_valid` for the F0 byte.
- Frames E0, 75 then E0, F0, 75 -> `key_ext`=1; `jump_held` goes 1 then 0.
- Frame 1C with flipped parity -> `rx_error` pulse, no `rx_valid`, `rx_data` unchanged. A following good F0, 1C still decodes as a 1C break.
- Stop after 5 data bits for 3 ms -> `rx_error` at `TIMEOUT_CYCLES`. The next full 29 frame decodes correctly.
- 3-cycle glitch on `ps2_clk` mid-frame, plus `reset` asserted mid-frame -> glitch ignored and frame correct. After reset all outputs 0 and the next frame decodes.
